// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types and constants for the io interrupt controller
package int_ctrl_pkg;

  localparam int NUM_SRC = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_CLEAR = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  localparam logic [7:0] CTRL_OFS   = 8'd0;
  localparam logic [7:0] STATUS_OFS = 8'd1;
  localparam int         GIE_BIT    = 7;
  // Writable CTRL bits: GIE plus the four source masks; bits[6:4] stay zero.
  localparam logic [7:0] CTRL_WMASK = 8'h8F;

  localparam int SRC_TOP    = 0;
  localparam int SRC_MATCH0 = 1;
  localparam int SRC_MATCH1 = 2;
  localparam int SRC_BLANK  = 3;

  function automatic logic [7:0] status_word(input logic irq, input logic [1:0] vec,
                                             input logic [3:0] pend);
    return {irq, 1'b0, vec, pend};
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - io write/read strobes plus the CPU irq/vector/ack handshake
interface int_ctrl_if;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic       irq_ack;
  logic       irq;
  logic [1:0] vector;

  modport master (output din, address, w_en, r_en, irq_ack, input irq, vector);
  modport slave  (input din, address, w_en, r_en, irq_ack, output irq, vector);
endinterface

// File: rtl/int_prio_arb.sv
// rtl/int_prio_arb.sv - combinational priority encoder searching from a start pointer
module int_prio_arb
  import int_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic               valid_o,
  output logic [1:0]         idx_o
);

  logic [1:0] cand;

  // A zero pointer degenerates to fixed lowest-index-first priority.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = 2'd0;
    cand    = 2'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = ptr_i + 2'(k);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - io interrupt controller top; INT_CTRL_ROUND_ROBIN_EN selects rotating priority
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [7:0] INT_CTRL_ADDRESS = 8'h0C
) (
  input  logic                clk,
  input  logic                rst_n,
  int_ctrl_if.slave           bus,
  output logic [7:0]          dout,
  input  logic [NUM_SRC-1:0]  src_flag,
  output logic [NUM_SRC-1:0]  flag_clr
);

  state_e              state_q, state_d;
  logic [7:0]          ctrl_q, ctrl_d;
  logic [1:0]          vector_q, vector_d;
  logic                irq_q, irq_d;
  logic [NUM_SRC-1:0]  hw_clr_q, hw_clr_d;
  logic [NUM_SRC-1:0]  sw_clr_q, sw_clr_d;

  logic                ctrl_hit, status_hit;
  logic [NUM_SRC-1:0]  pend;
  logic                arb_valid;
  logic [1:0]          arb_idx;
  logic [1:0]          arb_ptr;
  logic [7:0]          rdata;

  assign ctrl_hit   = (bus.address == INT_CTRL_ADDRESS + CTRL_OFS);
  assign status_hit = (bus.address == INT_CTRL_ADDRESS + STATUS_OFS);
  assign pend       = src_flag & ctrl_q[NUM_SRC-1:0];

`ifdef INT_CTRL_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_REQ && bus.irq_ack) ptr_d = vector_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end

  assign arb_ptr = ptr_q;
`else
  assign arb_ptr = 2'd0;
`endif

  int_prio_arb u_arb (
    .req_i   (pend),
    .ptr_i   (arb_ptr),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    irq_d    = irq_q;
    hw_clr_d = '0;
    sw_clr_d = (bus.w_en && status_hit) ? bus.din[NUM_SRC-1:0] : '0;
    ctrl_d   = (bus.w_en && ctrl_hit) ? (bus.din & CTRL_WMASK) : ctrl_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[GIE_BIT] && arb_valid) begin
          vector_d = arb_idx;
          irq_d    = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.irq_ack) begin
          irq_d    = 1'b0;
          hw_clr_d = NUM_SRC'(1) << vector_q;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_GUARD;
      // Let the peripheral flag fall before arbitrating again.
      ST_GUARD: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= 8'h00;
      vector_q <= 2'd0;
      irq_q    <= 1'b0;
      hw_clr_q <= '0;
      sw_clr_q <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      vector_q <= vector_d;
      irq_q    <= irq_d;
      hw_clr_q <= hw_clr_d;
      sw_clr_q <= sw_clr_d;
    end
  end

  assign flag_clr   = hw_clr_q | sw_clr_q;
  assign bus.irq    = irq_q;
  assign bus.vector = vector_q;

  assign rdata = status_hit ? status_word(irq_q, vector_q, pend) : ctrl_q;
  assign dout  = (bus.r_en && (ctrl_hit || status_hit)) ? rdata : 8'hzz;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - randomized and directed bench for int_ctrl against a behavioural model
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam logic [7:0] BASE = 8'h0C;
`ifdef INT_CTRL_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] src_flag;
  wire  [3:0] flag_clr;
  wire  [7:0] dout;

  always #5 clk = ~clk;

  int_ctrl_if bus ();

  int_ctrl #(.INT_CTRL_ADDRESS(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .dout     (dout),
    .src_flag (src_flag),
    .flag_clr (flag_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_ctrl;
  logic       m_irq;
  int         m_vec;
  int         m_cool;
  int         m_ptr;
  logic [3:0] m_clr;
  bit         periph_auto;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] p, input int start);
    for (int k = 0; k < 4; k++)
      if (p[(start + k) % 4]) return (start + k) % 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_ctrl = 8'h00; m_irq = 1'b0; m_vec = 0; m_cool = 0; m_ptr = 0; m_clr = 4'h0;
  endtask

  // One clock: model follows the rules at the edge, outputs compared 1 time unit later.
  task automatic tick();
    logic [7:0] c_din, c_addr;
    logic       c_w, c_ack;
    logic [3:0] c_src, prev_clr, sw, hw;
    c_din = bus.din; c_addr = bus.address; c_w = bus.w_en; c_ack = bus.irq_ack;
    c_src = src_flag; prev_clr = m_clr;
    @(posedge clk);
    sw = (c_w && c_addr == BASE + 8'd1) ? c_din[3:0] : 4'h0;
    hw = 4'h0;
    if (m_irq) begin
      if (c_ack) begin
        m_irq = 1'b0; hw = 4'(1 << m_vec); m_cool = 2; m_ptr = (m_vec + 1) % 4;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (m_ctrl[7] && (c_src & m_ctrl[3:0]) != 4'h0) begin
      m_vec = pick(c_src & m_ctrl[3:0], RR ? m_ptr : 0);
      m_irq = 1'b1;
    end
    if (c_w && c_addr == BASE) m_ctrl = c_din & 8'h8F;
    m_clr = sw | hw;
    #1;
    chk("irq", bus.irq, m_irq);
    chk("vector", bus.vector, m_vec[1:0]);
    chk("flag_clr", flag_clr, m_clr);
    if (periph_auto) src_flag = src_flag & ~prev_clr;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.w_en = 1'b1; bus.address = a; bus.din = d;
    tick();
    bus.w_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus.r_en = 1'b1; bus.address = a;
    #1;
    chk(tag, dout, exp);
    bus.r_en = 1'b0;
  endtask

  task automatic ack_once();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  int rr_vec[5];
  int exp_vec[5];
  int waited;

  initial begin
    bus.din = 8'h00; bus.address = 8'h00; bus.w_en = 1'b0; bus.r_en = 1'b0; bus.irq_ack = 1'b0;
    src_flag = 4'h0; periph_auto = 1'b1;
    model_reset();
    #12;
    chk("rst_irq", bus.irq, 1'b0);
    chk("rst_vector", bus.vector, 2'd0);
    chk("rst_flag_clr", flag_clr, 4'h0);
    rd_chk("rst_ctrl", BASE, 8'h00);
    rst_n = 1'b1;

    // Mask and GIE
    wr(BASE, 8'h81);
    rd_chk("ctrl_rd", BASE, 8'h81);
    src_flag = 4'b0001;
    tick();
    chk("a_irq", bus.irq, 1'b1);
    chk("a_vec", bus.vector, 2'd0);
    ack_once();
    repeat (3) tick();
    wr(BASE, 8'h01);
    src_flag = 4'b0001;
    repeat (3) tick();
    chk("gie0_irq", bus.irq, 1'b0);
    src_flag = 4'h0;

    // Fixed priority and ack-to-next latency
    wr(BASE, 8'h8F);
    src_flag = 4'b1100;
    tick();
    chk("prio_vec", bus.vector, 2'd2);
    ack_once();
    chk("prio_clr", flag_clr, 4'b0100);
    tick();
    chk("prio_clr_end", flag_clr, 4'b0000);
    tick();
    chk("prio_guard_irq", bus.irq, 1'b0);
    tick();
    chk("prio_next_irq", bus.irq, 1'b1);
    chk("prio_next_vec", bus.vector, 2'd3);
    rd_chk("status_rd", BASE + 8'd1, 8'hB8);
    ack_once();
    repeat (3) tick();
    chk("prio_drained", src_flag, 4'h0);

    // Software clear, alone and concurrent with a hardware ack
    wr(BASE + 8'd1, 8'h0A);
    chk("sw_clr", flag_clr, 4'b1010);
    tick();
    chk("sw_clr_end", flag_clr, 4'b0000);
    src_flag = 4'b0010;
    tick();
    chk("both_vec", bus.vector, 2'd1);
    bus.irq_ack = 1'b1;
    wr(BASE + 8'd1, 8'h02);
    bus.irq_ack = 1'b0;
    chk("both_clr", flag_clr, 4'b0010);
    tick();
    chk("both_clr_end", flag_clr, 4'b0000);
    repeat (3) tick();

    // Random traffic with peripherals retiring flags one cycle after their clear
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) src_flag = src_flag | 4'(1 << $urandom_range(0, 3));
      bus.irq_ack = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 29))
        0, 1: wr(BASE, 8'($urandom) | ($urandom_range(0, 3) != 0 ? 8'h80 : 8'h00));
        2:    wr(BASE + 8'd1, 8'($urandom));
        default: tick();
      endcase
      if ($urandom_range(0, 9) == 0)
        rd_chk("rand_status", BASE + 8'd1,
               status_word(m_irq, m_vec[1:0], src_flag & m_ctrl[3:0]));
    end
    bus.irq_ack = 1'b0;

    // Reset while in CLEAR
    src_flag = 4'h0;
    bus.irq_ack = 1'b1;
    repeat (4) tick();
    bus.irq_ack = 1'b0;
    wr(BASE, 8'h81);
    src_flag = 4'b0001;
    tick();
    ack_once();
    chk("mid_clr", flag_clr, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_clr", flag_clr, 4'h0);
    chk("mid_rst_irq", bus.irq, 1'b0);
    rd_chk("mid_rst_ctrl", BASE, 8'h00);
    model_reset();
    src_flag = 4'h0;
    #1 rst_n = 1'b1;
    tick();
    rd_chk("post_rst_status", BASE + 8'd1, 8'h00);

    // Priority rotation with every source held pending
    periph_auto = 1'b0;
    wr(BASE, 8'h8F);
    src_flag = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      waited = 0;
      while (!bus.irq && waited < 10) begin
        tick();
        waited++;
      end
      chk("rr_wait", bus.irq, 1'b1);
      rr_vec[r] = int'(bus.vector);
      exp_vec[r] = RR ? (r % 4) : 0;
      ack_once();
    end
    for (int r = 0; r < 5; r++) chk("rr_seq", rr_vec[r], exp_vec[r]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
